// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified instruction/data RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  // Misaligned or beyond the end of the RAM.
  function automatic logic addr_bad(input logic [63:0] addr, input int unsigned words);
    logic [63:0] word_idx;
    word_idx = addr >> WORD_SHIFT;
    return (addr[WORD_SHIFT-1:0] != '0) || (word_idx >= 64'(words));
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Winner pick between fetch and memory stage, with the data-streak limiter
// that guarantees fetch a slot after MAX_D_STREAK back-to-back data grants.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic    clk_i,
  input  logic    reset_i,
  input  logic    i_req_i,
  input  logic    d_req_i,
  input  logic    grant_i,
  output req_id_e winner_o,
  output logic    any_req_o
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          fetch_turn;

  always_comb begin
    fetch_turn = i_req_i && (streak_q == SW'(MAX_D_STREAK));
    winner_o   = (d_req_i && !fetch_turn) ? REQ_D : REQ_I;
    any_req_o  = i_req_i || d_req_i;
  end

  // Only grants where fetch was left waiting extend the streak.
  always_comb begin
    streak_d = streak_q;
    if (grant_i) begin
      if (winner_o == REQ_D && i_req_i) begin
        streak_d = streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM sequencer shared by fetch and memory stage.
// Optional performance counters: define MEM_ARB_PERF_CNT_EN.
//   state | meaning
//   IDLE  | waiting for a request, picks winner and checks address
//   ISSUE | mem_en pulse, RAM write commits here
//   WAIT  | MEM_LAT cycles for read data, captured on the last one
//   ACK   | one-cycle ack to the winner
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 8192,
  parameter int unsigned AW           = 13,
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [63:0]   i_addr,
  output logic          i_ack,
  output logic [63:0]   i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [63:0]   d_addr,
  input  logic [63:0]   d_wdata,
  output logic          d_ack,
  output logic [63:0]   d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata,
  output logic          busy
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]   perf_i_grants,
  output logic [31:0]   perf_d_grants,
  output logic [31:0]   perf_i_wait
`endif
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);

  arb_state_e    state_q;
  req_id_e       owner_q;
  logic          owner_we_q;
  logic [CW-1:0] lat_cnt_q;

  logic          i_ack_q;
  logic          i_err_q;
  logic [63:0]   i_rdata_q;
  logic          d_ack_q;
  logic          d_err_q;
  logic [63:0]   d_rdata_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [63:0]   mem_wdata_q;
  logic          busy_q;

  req_id_e       winner;
  logic          any_req;
  logic          grant;
  logic [63:0]   sel_addr;
  logic          sel_we;
  logic          sel_err;

  mem_arb_select #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_select (
    .clk_i    (clk),
    .reset_i  (reset),
    .i_req_i  (i_req),
    .d_req_i  (d_req),
    .grant_i  (grant),
    .winner_o (winner),
    .any_req_o(any_req)
  );

  always_comb begin
    grant    = (state_q == IDLE) && any_req;
    sel_addr = (winner == REQ_D) ? d_addr : i_addr;
    sel_we   = (winner == REQ_D) && d_we;
    sel_err  = addr_bad(sel_addr, MEM_WORDS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= REQ_I;
      owner_we_q  <= 1'b0;
      lat_cnt_q   <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      mem_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            owner_q    <= winner;
            owner_we_q <= sel_we;
            busy_q     <= 1'b1;
            if (sel_err) begin
              // Bad address never touches the RAM; ack straight away.
              state_q <= ACK;
              if (winner == REQ_D) begin
                d_ack_q   <= 1'b1;
                d_err_q   <= 1'b1;
                d_rdata_q <= '0;
              end else begin
                i_ack_q   <= 1'b1;
                i_err_q   <= 1'b1;
                i_rdata_q <= '0;
              end
            end else begin
              state_q     <= ISSUE;
              mem_en_q    <= 1'b1;
              mem_we_q    <= sel_we;
              mem_addr_q  <= sel_addr[AW+2:3];
              mem_wdata_q <= (winner == REQ_D) ? d_wdata : '0;
            end
          end
        end
        ISSUE: begin
          state_q   <= WAIT;
          mem_we_q  <= 1'b0;
          lat_cnt_q <= CW'(MEM_LAT - 1);
        end
        WAIT: begin
          if (lat_cnt_q == '0) begin
            state_q <= ACK;
            if (owner_q == REQ_D) begin
              d_ack_q   <= 1'b1;
              d_err_q   <= 1'b0;
              d_rdata_q <= owner_we_q ? '0 : mem_rdata;
            end else begin
              i_ack_q   <= 1'b1;
              i_err_q   <= 1'b0;
              i_rdata_q <= mem_rdata;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Gating with reset lets a reset during ISSUE abort the pending RAM write.
  assign mem_en    = mem_en_q && !reset;
  assign mem_we    = mem_we_q && !reset;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_i_grants_q;
  logic [31:0] perf_d_grants_q;
  logic [31:0] perf_i_wait_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_i_grants_q <= '0;
      perf_d_grants_q <= '0;
      perf_i_wait_q   <= '0;
    end else begin
      if (grant && winner == REQ_I) perf_i_grants_q <= perf_i_grants_q + 32'd1;
      if (grant && winner == REQ_D) perf_d_grants_q <= perf_d_grants_q + 32'd1;
      if (i_req && !(state_q == ACK && owner_q == REQ_I)) begin
        perf_i_wait_q <= perf_i_wait_q + 32'd1;
      end
    end
  end

  assign perf_i_grants = perf_i_grants_q;
  assign perf_d_grants = perf_d_grants_q;
  assign perf_i_wait   = perf_i_wait_q;
`endif

endmodule
